// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative unsigned restoring divider with done pulse and divide-by-zero flag
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   p;

    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   p_next;
    logic             ge;
    logic [WIDTH-1:0] quo_next;

    // One restoring step: bring in the next dividend bit, subtract the divisor if it fits.
    always_comb begin
        p_shift  = {p[WIDTH-1:0], dvd[WIDTH-1]};
        ge       = (p_shift >= {1'b0, dvs});
        p_next   = ge ? (p_shift - {1'b0, dvs}) : p_shift;
        quo_next = {quo[WIDTH-2:0], ge};
    end

    // Control FSM and datapath registers; results are loaded only at completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            quo   <= '0;
            p     <= '0;
            q     <= '0;
            r     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dbz   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd  <= a;
                        dvs  <= b;
                        quo  <= '0;
                        p    <= '0;
                        busy <= 1'b1;
                        if (b != '0) begin
                            cnt   <= CW'(WIDTH);
                            state <= CALC;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                CALC: begin
                    p   <= p_next;
                    dvd <= {dvd[WIDTH-2:0], 1'b0};
                    quo <= quo_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        q     <= quo_next;
                        r     <= p_next[WIDTH-1:0];
                        dbz   <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (done) begin
                        // Pulse already shown for one cycle: release busy and go idle.
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        // Divide-by-zero entry: dvd still holds the untouched dividend.
                        q    <= '1;
                        r    <= dvd;
                        dbz  <= 1'b1;
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
